// File: rtl/shift_reg_load_ctrl.sv
// shift_reg_load_ctrl: loads configuration words MSB first into an external serial shift
// register. Generates SCLK, serial data and a latch-enable pulse, then pulses o_done.
// Words are handed over with a valid/ready handshake; nothing is queued while busy.
// Optional build macro SHIFT_READBACK_EN adds i_sdi/o_rdata: the bits the external
// device shifts out are captured while the word is loaded.
module shift_reg_load_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LE_CYCLES  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sclk,
  output logic                  o_sdata,
  output logic                  o_le,
  output logic                  o_busy,
  output logic                  o_done
`ifdef SHIFT_READBACK_EN
  ,
  input  logic                  i_sdi,
  output logic [DATA_WIDTH-1:0] o_rdata
`endif
);

  localparam int unsigned PhW  = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned LeW  = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;

  localparam logic [PhW-1:0]  PhLast  = PhW'(2 * CLK_DIV - 1);
  localparam logic [PhW-1:0]  PhHigh  = PhW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);
  localparam logic [LeW-1:0]  LeLast  = LeW'(LE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [BitW-1:0]         bit_q;
  logic [PhW-1:0]          phase_q;
  logic [LeW-1:0]          le_cnt_q;
  logic [PhW-1:0]          phase_inc;

`ifdef SHIFT_READBACK_EN
  logic [DATA_WIDTH-1:0]   rx_q;
`endif

  assign phase_inc = phase_q + PhW'(1);

  // Sequencer: handshake, SCLK phase generation, bit shifting and latch pulse, all registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      le_cnt_q <= '0;
      o_ready  <= 1'b1;
      o_sclk   <= 1'b0;
      o_sdata  <= 1'b0;
      o_le     <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
`ifdef SHIFT_READBACK_EN
      rx_q     <= '0;
      o_rdata  <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_valid && o_ready) begin
            state_q <= StShift;
            shreg_q <= i_data;
            bit_q   <= '0;
            phase_q <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            o_sclk  <= 1'b0;
            o_sdata <= i_data[DATA_WIDTH-1];
`ifdef SHIFT_READBACK_EN
            rx_q    <= '0;
`endif
          end
        end

        StShift: begin
          if (phase_q == PhLast) begin
            // End of the high phase: SCLK falls and data moves on the same edge.
            phase_q <= '0;
            o_sclk  <= 1'b0;
            if (bit_q == BitLast) begin
              state_q  <= StLatch;
              o_sdata  <= 1'b0;
              o_le     <= 1'b1;
              le_cnt_q <= '0;
            end else begin
              bit_q   <= bit_q + BitW'(1);
              // Rotate so the next bit to send always sits just below the MSB.
              shreg_q <= {shreg_q[DATA_WIDTH-2:0], shreg_q[DATA_WIDTH-1]};
              o_sdata <= shreg_q[DATA_WIDTH-2];
            end
          end else begin
            phase_q <= phase_inc;
            o_sclk  <= (phase_inc >= PhHigh);
          end
`ifdef SHIFT_READBACK_EN
          // Capture at the end of the first high-phase cycle of each bit.
          if (phase_q == PhHigh) begin
            rx_q <= {rx_q[DATA_WIDTH-2:0], i_sdi};
          end
`endif
        end

        StLatch: begin
          if (le_cnt_q == LeLast) begin
            state_q <= StIdle;
            o_le    <= 1'b0;
            o_done  <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            bit_q   <= '0;
`ifdef SHIFT_READBACK_EN
            o_rdata <= rx_q;
`endif
          end else begin
            le_cnt_q <= le_cnt_q + LeW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_load_ctrl.sv
// Directed bench for shift_reg_load_ctrl: a scoreboard queue holds the expected serial bits,
// pushed when a word is accepted and popped on every observed SCLK rising edge.
module tb_shift_reg_load_ctrl;

  localparam int DW = 8;
`ifdef SHIFT_READBACK_EN
  localparam int CD = 1;
`else
  localparam int CD = 2;
`endif
  localparam int LE = 1;
  localparam int DONE_CYC = 2 * CD * DW + LE + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          o_ready, o_sclk, o_sdata, o_le, o_busy, o_done;
`ifdef SHIFT_READBACK_EN
  logic          sdi;
  logic [DW-1:0] o_rdata;
  logic [DW-1:0] rb_word = '0;
  int            rb_idx = 0;
`endif

  int   errs = 0;
  int   checks = 0;
  bit   mon_on = 0;
  bit   sb_en = 0;
  logic exp_q[$];
  int   rise_cnt = 0, le_cnt = 0, done_cnt = 0, hi_len = 0, le_len = 0;
  logic sclk_p = 0, sdata_p = 0, le_p = 0, done_p = 0;

  shift_reg_load_ctrl #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CD),
    .LE_CYCLES (LE)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_valid(valid),
    .o_ready(o_ready),
    .o_sclk (o_sclk),
    .o_sdata(o_sdata),
    .o_le   (o_le),
    .o_busy (o_busy),
    .o_done (o_done)
`ifdef SHIFT_READBACK_EN
    ,
    .i_sdi  (sdi),
    .o_rdata(o_rdata)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {o_ready, o_sclk, o_sdata, o_le, o_busy, o_done};
  endfunction

  // Monitor on the falling clock edge, away from the active edge.
  always @(negedge clk) begin
    logic e;
    if (mon_on) begin
      if (sb_en) begin
        if (o_sclk && !sclk_p) begin
          rise_cnt++;
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sdata_bit", o_sdata, e);
          end
`ifdef SHIFT_READBACK_EN
          sdi = rb_word[DW-1-(rb_idx % DW)];
          rb_idx++;
`endif
        end
        if (o_sclk) begin
          hi_len++;
          chk("sdata_stable_hi", o_sdata, sdata_p);
        end else if (sclk_p) begin
          chk("sclk_hi_len", hi_len, CD);
          hi_len = 0;
        end
      end else begin
        hi_len = 0;
      end
      if (o_le && !le_p) le_cnt++;
      if (o_le) begin
        le_len++;
        chk("latch_lines", {o_sclk, o_sdata}, 0);
      end else if (le_p) begin
        chk("le_len", le_len, LE);
        le_len = 0;
      end
      if (o_done) begin
        done_cnt++;
        chk("done_single", done_p, 0);
      end
    end
    sclk_p  = o_sclk;
    sdata_p = o_sdata;
    le_p    = o_le;
    done_p  = o_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // Drive a word and advance through its acceptance edge; leaves the bench one step after it.
  task automatic send_word(input logic [DW-1:0] w, input bit hold);
    int   n;
    logic r;
    valid = 1'b1;
    data  = w;
    n = 0;
    do begin
      r = o_ready;
      step();
      n++;
    end while (!r && n < 200);
    if (r !== 1'b1) chk("accept_timeout", 0, 1);
    push_word(w);
    if (!hold) valid = 1'b0;
    chk("accept_state", outs(), {1'b0, 1'b0, w[DW-1], 1'b0, 1'b1, 1'b0});
  endtask

  task automatic wait_done(input int start, output int cyc, output logic rdy_bad);
    cyc = start;
    rdy_bad = 1'b0;
    while (o_done !== 1'b1 && cyc < 400) begin
      if (o_ready !== 1'b0) rdy_bad = 1'b1;
      step();
      cyc++;
    end
  endtask

  initial begin
    int   cyc, n, r0, l0, d0;
    logic bad;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
`ifdef SHIFT_READBACK_EN
    sdi   = 1'b0;
`endif
    repeat (3) step();
    chk("reset_outputs", outs(), 6'b100000);
`ifdef SHIFT_READBACK_EN
    chk("reset_rdata", o_rdata, 0);
`endif
    rst    = 1'b0;
    mon_on = 1;
    sb_en  = 1;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outputs", outs(), 6'b100000);
    end

    // Single word.
    r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
    send_word(8'hA5, 0);
    wait_done(1, cyc, bad);
    chk("a5_done_cycle", cyc, DONE_CYC);
    chk("a5_ready_low", bad, 0);
    chk("a5_done_outputs", outs(), 6'b100001);
    step();
    chk("a5_rises", rise_cnt - r0, 8);
    chk("a5_le_pulses", le_cnt - l0, 1);
    chk("a5_dones", done_cnt - d0, 1);
    chk("a5_after_done", outs(), 6'b100000);
    chk("a5_sb_empty", exp_q.size(), 0);

    // Back-to-back words with valid held high.
    r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
    send_word(8'hFF, 1);
    data = 8'h00;
    wait_done(1, cyc, bad);
    chk("b2b_first_done_cycle", cyc, DONE_CYC);
    chk("b2b_done_ready", {o_done, o_ready}, 2'b11);
    step();
    chk("b2b_no_gap", {o_ready, o_busy, o_sdata}, 3'b010);
    push_word(8'h00);
    valid = 1'b0;
    wait_done(1, cyc, bad);
    chk("b2b_second_done_cycle", cyc, DONE_CYC);
    step();
    chk("b2b_rises", rise_cnt - r0, 16);
    chk("b2b_le_pulses", le_cnt - l0, 2);
    chk("b2b_dones", done_cnt - d0, 2);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // Request while busy must be ignored.
    r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
    send_word(8'h81, 0);
    repeat (5) step();
    valid = 1'b1;
    data  = 8'h3C;
    step();
    valid = 1'b0;
    wait_done(7, cyc, bad);
    chk("ign_done_cycle", cyc, DONE_CYC);
    repeat (2 * CD * DW + 4) step();
    chk("ign_rises", rise_cnt - r0, 8);
    chk("ign_dones", done_cnt - d0, 1);
    chk("ign_le_pulses", le_cnt - l0, 1);
    chk("ign_idle", outs(), 6'b100000);
    chk("ign_sb_empty", exp_q.size(), 0);

    // Reset after the third SCLK rise.
    r0 = rise_cnt;
    send_word(8'hC3, 0);
    n = 0;
    while (rise_cnt - r0 < 3 && n < 200) begin
      step();
      n++;
    end
    chk("rst_third_rise", rise_cnt - r0, 3);
    sb_en = 0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    chk("rst_mid_outputs", outs(), 6'b100000);
`ifdef SHIFT_READBACK_EN
    chk("rst_mid_rdata", o_rdata, 0);
`endif
    exp_q.delete();
    l0 = le_cnt; d0 = done_cnt;
    repeat (DONE_CYC + 4) step();
    chk("rst_no_le", le_cnt - l0, 0);
    chk("rst_no_done", done_cnt - d0, 0);
    sb_en = 1;
    r0 = rise_cnt; d0 = done_cnt;
    send_word(8'h5A, 0);
    wait_done(1, cyc, bad);
    chk("post_rst_done_cycle", cyc, DONE_CYC);
    step();
    chk("post_rst_rises", rise_cnt - r0, 8);
    chk("post_rst_dones", done_cnt - d0, 1);
    chk("post_rst_sb_empty", exp_q.size(), 0);

`ifdef SHIFT_READBACK_EN
    // Readback of the serial input pattern.
    rb_word = 8'h96;
    rb_idx  = 0;
    send_word(8'h96, 0);
    wait_done(1, cyc, bad);
    chk("rb_done_cycle", cyc, 18);
    chk("rb_rdata", o_rdata, 8'h96);
    repeat (3) step();
    chk("rb_rdata_hold", o_rdata, 8'h96);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
